tagged_stream_reader: RTL
=========================

TAGGED_STREAM_READER -- requirements
Module: tagged_stream_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 16, per-stream FIFO depth in words, power of two, >= 2.
REQ-002 SHALL have parameter FLUX, default 2, number of tagged streams, >= 2.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, payload width; TAG_WIDTH = $clog2(FLUX).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 wr_din  input  DATA_WIDTH+TAG_WIDTH  write word; tag in upper TAG_WIDTH bits, payload in lower DATA_WIDTH bits.
REQ-007 wr_write  input  1  write strobe; one word offered per cycle when high.
REQ-008 wr_full  output  FLUX  bit i high when stream i FIFO holds DEPTH words.
REQ-009 rd_dout  output  DATA_WIDTH+TAG_WIDTH  registered output word, same tag/payload layout as wr_din.
REQ-010 rd_valid  output  1  rd_dout holds a valid word.
REQ-011 rd_ready  input  1  downstream accepts rd_dout this cycle.
REQ-012 rd_empty  output  FLUX  bit i high when stream i FIFO holds 0 words.
REQ-013 err_drop  output  1  sticky flag: a write was discarded.

Function
REQ-014 A write with wr_write=1, tag t < FLUX and wr_full[t]=0 SHALL store the payload in FIFO t on that edge.
REQ-015 A write to a full FIFO SHALL be discarded and set err_drop, even if the same FIFO is popped in that cycle; no pass-through.
REQ-016 A write with tag >= FLUX SHALL be discarded and set err_drop.
REQ-017 err_drop SHALL stay high until reset.
REQ-018 Each FIFO SHALL keep an occupancy count 0..DEPTH; a simultaneous accepted write and pop on one FIFO SHALL leave the count unchanged.
REQ-019 Read/write pointers SHALL wrap modulo DEPTH; wr_full and rd_empty SHALL be decoded from registered counts.
REQ-020 The output register SHALL load when rd_valid=0 or rd_ready=1; otherwise rd_dout and rd_valid SHALL hold.
REQ-021 On load, the arbiter SHALL grant the first non-empty stream after the last-granted index, wrapping round-robin, and pop one word from it.
REQ-022 If no stream is non-empty at a load, rd_valid SHALL go 0.
REQ-023 rd_dout SHALL carry the granted stream index in its tag field.
REQ-024 Latency: a word written on edge E into an empty system SHALL appear with rd_valid=1 after edge E+1; there is no same-cycle bypass.
REQ-025 With rd_ready held high and data available, throughput SHALL be one word per cycle.
REQ-026 Words within a stream SHALL leave in arrival order; no word SHALL be duplicated or lost except per REQ-015/016.

Reset
REQ-027 While rst=0: all counts and pointers 0, rd_valid=0, rd_dout=0, err_drop=0, wr_full all 0, rd_empty all 1, last-granted index FLUX-1 so stream 0 is granted first.
REQ-028 Reset asserted mid-operation SHALL discard all buffered words and the output register immediately, without waiting for clk.
REQ-029 FIFO storage arrays need not be reset; only control state is.

Structure
REQ-030 A shared package SHALL hold the DATA_WIDTH default, the TAG_WIDTH derivation function and the tag/payload field-split helpers, shared with the writer side.
REQ-031 One sub-module, stream_fifo (single stream: storage, pointers, count, full/empty), SHALL be instantiated FLUX times; arbiter and output register live in the top.

Verification
REQ-032 Reset then write 0x0_A5 (tag 0) with rd_ready=1 -> rd_valid=1 with rd_dout=0x0_A5 after the following edge; rd_empty=2'b11 afterwards.
REQ-033 rd_ready=0, write 16 words to tag 1 -> wr_full[1]=1 after the 16th; 17th write dropped, err_drop=1; drained order and values match the first 16.
REQ-034 Preload tag 0 with 0x10..0x13 and tag 1 with 0x20..0x23, then rd_ready=1 -> output order 0x10,0x20,0x11,0x21,... at one word per cycle.
REQ-035 Stall: rd_valid=1, rd_ready=0 for 5 cycles -> rd_dout stable; releasing rd_ready pops exactly one word per cycle.
REQ-036 Assert rst mid-stream with 8 words buffered -> outputs reach reset values asynchronously; after release, no stale word appears.
REQ-037 FLUX=3: write tag 3 -> word discarded, err_drop=1, no FIFO count changes.

Source files
------------

// File: rtl/tagged_stream_reader_pkg.sv
// Shared definitions for the tagged stream writer/reader pair: default payload
// width, tag width derivation and the tag/payload field helpers.
package tagged_stream_reader_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 8;

  // Widest word the helpers handle; callers cast in and out of this width.
  localparam int unsigned MAX_WORD_WIDTH = 64;

  typedef logic [MAX_WORD_WIDTH-1:0] word_t;

  // Number of tag bits needed to name every stream.
  function automatic int unsigned tag_width(input int unsigned flux);
    return (flux > 1) ? unsigned'($clog2(flux)) : 1;
  endfunction

  // Tag sits directly above the payload.
  function automatic word_t word_tag(input word_t word, input int unsigned data_width);
    return word >> data_width;
  endfunction

  function automatic word_t word_payload(input word_t word, input int unsigned data_width);
    return word & ((word_t'(1) << data_width) - word_t'(1));
  endfunction

  function automatic word_t make_word(input word_t tag, input word_t payload,
                                      input int unsigned data_width);
    return (tag << data_width) | payload;
  endfunction

endpackage

// File: rtl/tagged_stream_reader_fifo.sv
// Single-stream FIFO: storage, wrapping pointers and an occupancy count from
// which full/empty are decoded. Push/pop are ignored when they cannot apply.
module stream_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CNT_WIDTH'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage write port.
  // NOTE: the data array has no reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tagged_stream_reader.sv
// Tagged stream reader: demultiplexes tagged writes into per-stream FIFOs and
// merges them round-robin into one registered ready/valid output.
module tagged_stream_reader
  import tagged_stream_reader_pkg::*;
#(
  parameter int unsigned  DEPTH      = 16,
  parameter int unsigned  FLUX       = 2,
  parameter int unsigned  DATA_WIDTH = DATA_WIDTH_DEFAULT,
  localparam int unsigned TAG_WIDTH  = tag_width(FLUX)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH+TAG_WIDTH-1:0] wr_din,
  input  logic                            wr_write,
  output logic [FLUX-1:0]                 wr_full,
  output logic [DATA_WIDTH+TAG_WIDTH-1:0] rd_dout,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [FLUX-1:0]                 rd_empty,
  output logic                            err_drop
);

  localparam int unsigned WORD_WIDTH = DATA_WIDTH + TAG_WIDTH;

  logic [TAG_WIDTH-1:0]  wr_tag;
  logic [DATA_WIDTH-1:0] wr_payload;
  logic                  tag_ok;
  logic [FLUX-1:0]       push;
  logic [FLUX-1:0]       pop;
  logic                  drop;
  logic                  load;
  logic [DATA_WIDTH-1:0] fifo_dout [FLUX];
  logic [TAG_WIDTH-1:0]  last_grant;
  logic [TAG_WIDTH-1:0]  grant_idx;
  logic [TAG_WIDTH-1:0]  cand;
  logic                  grant_found;

  assign wr_tag     = TAG_WIDTH'(word_tag(word_t'(wr_din), DATA_WIDTH));
  assign wr_payload = DATA_WIDTH'(word_payload(word_t'(wr_din), DATA_WIDTH));
  assign tag_ok     = (32'(wr_tag) < FLUX);

  // A write that no FIFO accepts (bad tag or full target) is a drop.
  assign drop = wr_write && !(|push);
  assign load = !rd_valid || rd_ready;

  for (genvar i = 0; i < FLUX; i++) begin : g_stream
    // Full is judged on the registered count, so a same-cycle pop never makes room.
    assign push[i] = wr_write && tag_ok && (wr_tag == TAG_WIDTH'(i)) && !wr_full[i];
    assign pop[i]  = load && grant_found && (grant_idx == TAG_WIDTH'(i));

    stream_fifo #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (wr_payload),
      .dout  (fifo_dout[i]),
      .full  (wr_full[i]),
      .empty (rd_empty[i])
    );
  end

  // Round-robin search: first non-empty stream after the last one granted.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= FLUX; k++) begin
      cand = TAG_WIDTH'((32'(last_grant) + k) % FLUX);
      if (!grant_found && !rd_empty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Output register, grant pointer and sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid   <= 1'b0;
      rd_dout    <= '0;
      last_grant <= TAG_WIDTH'(FLUX - 1);
      err_drop   <= 1'b0;
    end else begin
      if (drop) err_drop <= 1'b1;
      if (load) begin
        rd_valid <= grant_found;
        if (grant_found) begin
          rd_dout    <= WORD_WIDTH'(make_word(word_t'(grant_idx),
                                              word_t'(fifo_dout[grant_idx]), DATA_WIDTH));
          last_grant <= grant_idx;
        end
      end
    end
  end

endmodule
